arith_result_stage: RTL and testbench
=====================================

Name: arith_result_stage

Overview:
- Registered output stage placed directly downstream of the combinational arithmetic-shift unit in the synchronous arithmetic unit.
- Captures each shift result and its error flag through a valid/ready handshake into a 2-entry buffer, so the shifter never stalls on back-pressure for one cycle.
- Derives sign and zero flags for the downstream consumer.
- Keeps operation and error statistics: a sticky error flag, a saturating error counter and a wrapping operation counter.

Parameters:
- BITS, 32, data width of the result; must match the shift unit's BITS.
- CNT_W, 8, width of the error and operation counters.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream result valid.
- o_ready  out  1  stage can accept a result this cycle.
- i_result  in  BITS  result from the shift unit; sign-magnitude, MSB is the sign.
- i_error  in  1  error flag from the shift unit.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts the head this cycle.
- o_result  out  BITS  head result.
- o_error  out  1  head error flag.
- o_sign  out  1  head result MSB.
- o_zero  out  1  head magnitude is zero: +0 or -0, with o_error=0.
- i_clr_status  in  1  synchronous clear of the statistics.
- o_err_sticky  out  1  an errored result has been delivered since the last clear or reset.
- o_err_count  out  CNT_W  delivered errored results, saturating.
- o_op_count  out  CNT_W  delivered results, wrapping.

Behaviour:
- Reset, asynchronous: buffer empty; o_valid=0, o_ready=1, o_result=0, o_error=0, o_sign=0, o_zero=0; all statistics 0. Reset mid-transfer discards buffered entries with no partial output.
- Push = i_valid & o_ready. Pop = o_valid & i_ready.
- o_ready is a registered value: 1 when occupancy < 2.
- o_valid = occupancy > 0. Head outputs come straight from the head register, with no combinational path from i_result.
- Latency: a result pushed in cycle N is presented with o_valid=1 in cycle N+1.
- Occupancy transitions:
  - 0 -> 1 on push.
  - 1 -> 2 on push without pop.
  - 1 -> 0 on pop without push.
  - 1 stays 1 on push with pop; the new entry becomes head in the next cycle.
  - 2 -> 1 on pop; the tail moves to head.
  - A push while full is impossible because o_ready=0.
- When empty, the head registers hold their last values while o_valid=0. The consumer ignores them.
- Flags: o_sign = o_result[BITS-1]; o_zero = (o_result[BITS-2:0]==0) & ~o_error.
- Statistics update only on pop:
  - o_op_count += 1, wrapping from 2**CNT_W-1 to 0.
  - If the popped entry has o_error=1: o_err_count += 1, saturating at 2**CNT_W-1; o_err_sticky <= 1.
- i_clr_status: counters and sticky load 0, then the same-cycle pop is counted. Clear with an errored pop therefore gives op=1, err=1, sticky=1.
- Data path is pure register transfer. No arithmetic on i_result.

Decomposition:
- Shared package (used with the shift unit):
  - BITS default.
  - Typedef for a result entry: struct {logic [BITS-1:0] result; logic error;}.
  - Occupancy enum: EMPTY, ONE, FULL.
- Natural sub-module: result_skid_buf, the 2-entry buffer with handshake.
- The top level adds the flag decode and statistics.

Test Plan:
- Single transfer: after reset, push i_result=32'h0000_0010, i_error=0, i_ready=1 -> next cycle o_valid=1, o_result=32'h0000_0010, o_sign=0, o_zero=0; op_count=1 after the pop.
- Back-pressure: i_ready=0, push 32'h1 then 32'h2 -> o_ready=0 after the second push. Third i_valid is not accepted. Release i_ready -> 32'h1 then 32'h2 out in order, then o_valid=0.
- Zero flags: push 32'h8000_0000 (-0) and 32'h0, both with error=0 -> o_zero=1 for both; o_sign=1 then 0.
- Errors and saturation (CNT_W=2): deliver 5 errored results -> err_count sticks at 3, op_count=1 after wrap, sticky=1. i_clr_status with an idle bus -> all statistics 0.
- Clear with simultaneous errored pop -> op_count=1, err_count=1, sticky=1.
- Asynchronous reset asserted mid-cycle with occupancy 2 -> outputs drop to reset values immediately, without waiting for a clock edge; o_ready=1 after release.

Source files
------------

// File: rtl/arith_result_stage_pkg.sv
// Shared definitions for the arithmetic-shift unit and its registered result stage.
package arith_result_stage_pkg;

  // Default result width; the shift unit and the result stage must agree on it.
  localparam int BITS_DEF = 32;

  // One result as produced by the shift unit: sign-magnitude value plus error flag.
  typedef struct packed {
    logic [BITS_DEF-1:0] result;
    logic                error;
  } result_entry_t;

  // Occupancy of the two-entry result buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/arith_result_stage_result_skid_buf.sv
// Two-entry skid buffer with valid/ready handshake on both sides.
// The head entry is driven straight from a register, and ready is registered too,
// so neither side sees a combinational path through the buffer.
module result_skid_buf
  import arith_result_stage_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  occ_e         r_occ;
  logic         r_ready;

  logic w_push;
  logic w_pop;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = (r_occ != EMPTY) & i_ready;
  assign o_ready = r_ready;
  assign o_valid = (r_occ != EMPTY);
  assign o_data  = r_head;

  // Occupancy state, head/tail storage and registered ready; a full buffer never pushes
  // because ready was already dropped, so FULL only has to handle a pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_occ   <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
      r_ready <= 1'b1;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (w_push) begin
            r_head <= i_data;
            r_occ  <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail  <= i_data;
            r_occ   <= FULL;
            r_ready <= 1'b0;
          end else if (w_pop) begin
            r_occ <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_occ   <= ONE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_occ   <= EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/arith_result_stage.sv
// Registered output stage behind the arithmetic-shift unit: buffers results,
// decodes sign/zero flags of the head entry and keeps delivery statistics.
module arith_result_stage
  import arith_result_stage_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [BITS-1:0]  i_result,
  input  logic             i_error,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BITS-1:0]  o_result,
  output logic             o_error,
  output logic             o_sign,
  output logic             o_zero,
  input  logic             i_clr_status,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_op_count
);

  logic [BITS:0]    w_in_data;
  logic [BITS:0]    w_head_data;
  logic             w_valid;
  logic             w_pop;
  logic             w_pop_err;

  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_op_count;

  assign w_in_data = {i_result, i_error};

  result_skid_buf #(
    .W (BITS + 1)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (w_in_data),
    .o_valid (w_valid),
    .i_ready (i_ready),
    .o_data  (w_head_data)
  );

  assign o_valid   = w_valid;
  assign o_result  = w_head_data[BITS:1];
  assign o_error   = w_head_data[0];
  assign o_sign    = o_result[BITS-1];
  // Zero is qualified by valid so the reset/idle head (all zeros) does not report +0.
  assign o_zero    = w_valid & (o_result[BITS-2:0] == '0) & ~o_error;

  assign w_pop     = w_valid & i_ready;
  assign w_pop_err = w_pop & o_error;

  assign o_err_sticky = r_err_sticky;
  assign o_err_count  = r_err_count;
  assign o_op_count   = r_op_count;

  // Statistics count delivered results; a clear zeroes them and then counts this cycle's pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
      r_op_count   <= '0;
    end else if (i_clr_status) begin
      r_err_sticky <= w_pop_err;
      r_err_count  <= w_pop_err ? CNT_W'(1) : '0;
      r_op_count   <= w_pop ? CNT_W'(1) : '0;
    end else if (w_pop) begin
      r_op_count <= r_op_count + CNT_W'(1);
      if (o_error) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != {CNT_W{1'b1}}) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_result_stage.sv
// Self-checking bench for arith_result_stage with a queue-based reference model.
module tb_arith_result_stage;

   localparam int BITS  = 32;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [BITS-1:0] res;
      logic            err;
   } entryT;

   logic             clk;
   logic             rst;
   logic             iValid;
   logic             oReady;
   logic [BITS-1:0]  iResult;
   logic             iError;
   logic             oValid;
   logic             iReady;
   logic [BITS-1:0]  oResult;
   logic             oError;
   logic             oSign;
   logic             oZero;
   logic             iClrStatus;
   logic             oErrSticky;
   logic [CNT_W-1:0] oErrCount;
   logic [CNT_W-1:0] oOpCount;

   entryT           modelQ[$];
   logic [BITS-1:0] lastRes;
   logic            lastErr;
   int              modelOps;
   int              modelErrs;
   logic            modelSticky;

   int totalChecks;
   int passedChecks;
   int failedChecks;

   arith_result_stage #(
      .BITS  (BITS),
      .CNT_W (CNT_W)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (iValid),
      .o_ready      (oReady),
      .i_result     (iResult),
      .i_error      (iError),
      .o_valid      (oValid),
      .i_ready      (iReady),
      .o_result     (oResult),
      .o_error      (oError),
      .o_sign       (oSign),
      .o_zero       (oZero),
      .i_clr_status (iClrStatus),
      .o_err_sticky (oErrSticky),
      .o_err_count  (oErrCount),
      .o_op_count   (oOpCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and reports a failure with tag and both values.
   task automatic checkVal(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
      totalChecks++;
      assert (obs === exp) passedChecks++;
      else begin
         failedChecks++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Return the model to its post-reset state.
   task automatic modelReset();
      modelQ.delete();
      lastRes     = '0;
      lastErr     = 1'b0;
      modelOps    = 0;
      modelErrs   = 0;
      modelSticky = 1'b0;
   endtask

   // Compare every DUT output against what the model says it should show now.
   task automatic checkOutput(input string tag);
      logic expValid;
      logic expZero;
      expValid = (modelQ.size() > 0);
      expZero  = expValid && (lastRes[BITS-2:0] == '0) && !lastErr;
      checkVal({tag, ".valid"},  BITS'(oValid),     BITS'(expValid));
      checkVal({tag, ".ready"},  BITS'(oReady),     BITS'(modelQ.size() < 2));
      checkVal({tag, ".result"}, oResult,           lastRes);
      checkVal({tag, ".error"},  BITS'(oError),     BITS'(lastErr));
      checkVal({tag, ".sign"},   BITS'(oSign),      BITS'(lastRes[BITS-1]));
      checkVal({tag, ".zero"},   BITS'(oZero),      BITS'(expZero));
      checkVal({tag, ".sticky"}, BITS'(oErrSticky), BITS'(modelSticky));
      checkVal({tag, ".errcnt"}, BITS'(oErrCount),  BITS'(modelErrs));
      checkVal({tag, ".opcnt"},  BITS'(oOpCount),   BITS'(modelOps % (CNT_MAX + 1)));
   endtask

   // Drive one cycle of inputs, advance the model across the clock edge, then check.
   task automatic applyStimulus(input logic v, input logic [BITS-1:0] data, input logic e,
                                input logic rdy, input logic clr, input string tag);
      logic  doPush;
      logic  doPop;
      entryT popped;
      entryT incoming;
      iValid     = v;
      iResult    = data;
      iError     = e;
      iReady     = rdy;
      iClrStatus = clr;
      doPush = v && (modelQ.size() < 2);
      doPop  = rdy && (modelQ.size() > 0);
      @(posedge clk);
      #1;
      if (clr) begin
         modelOps    = 0;
         modelErrs   = 0;
         modelSticky = 1'b0;
      end
      if (doPop) begin
         popped   = modelQ.pop_front();
         modelOps = modelOps + 1;
         if (popped.err) begin
            modelSticky = 1'b1;
            if (modelErrs < CNT_MAX) modelErrs = modelErrs + 1;
         end
      end
      if (doPush) begin
         incoming.res = data;
         incoming.err = e;
         modelQ.push_back(incoming);
      end
      if (modelQ.size() > 0) begin
         lastRes = modelQ[0].res;
         lastErr = modelQ[0].err;
      end
      checkOutput(tag);
   endtask

   initial begin
      logic [BITS-1:0] rData;
      int              pick;
      totalChecks  = 0;
      passedChecks = 0;
      failedChecks = 0;
      rst        = 1'b1;
      iValid     = 1'b0;
      iResult    = '0;
      iError     = 1'b0;
      iReady     = 1'b0;
      iClrStatus = 1'b0;
      modelReset();

      // Reset state
      #12;
      checkOutput("reset");
      rst = 1'b0;

      // Single transfer
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b0, "single.push");
      applyStimulus(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, "single.pop");

      // Back-pressure: fill, try a third push, then drain in order
      applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, "bp.push1");
      applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, "bp.push2");
      applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, "bp.push3");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "bp.pop1");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "bp.pop2");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "bp.idle");

      // Zero flags for -0 and +0
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "zero.neg");
      applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "zero.pos");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "zero.pop1");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "zero.pop2");

      // Errors with saturation and wrap, then an idle clear
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "sat.clr0");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h0000_0100 + i, 1'b1, 1'b1, 1'b0, "sat.stream");
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "sat.drain");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "sat.clr");

      // Clear together with an errored pop
      applyStimulus(1'b1, 32'h0000_0055, 1'b1, 1'b0, 1'b0, "clrpop.push");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, "clrpop.clr");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         pick = $urandom_range(0, 3);
         if (pick == 0)      rData = 32'h8000_0000;
         else if (pick == 1) rData = 32'h0;
         else                rData = $urandom;
         applyStimulus(1'($urandom_range(0, 1)), rData, 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rand");
      end

      // Asynchronous reset between clock edges with the buffer full
      applyStimulus(1'b1, 32'h8000_00AA, 1'b1, 1'b0, 1'b0, "arst.fill1");
      applyStimulus(1'b1, 32'h0000_00BB, 1'b0, 1'b0, 1'b0, "arst.fill2");
      iValid = 1'b0;
      rst    = 1'b1;
      #1;
      modelReset();
      checkOutput("arst.during");
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "arst.after");

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
